// File: rtl/serial_addsub_if.sv
// Start/done handshake bundle for the serial adder/subtractor.
// The controller drives the operation request and the adder returns status and result.
interface serial_addsub_if #(
   parameter int WIDTH = 8
) ();
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, a, b,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: a STEP-bit ripple slice per clock, carry held between cycles.
// Result, carry-out and overflow stay held until the next operation completes.
module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int STEP  = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_addsub_if.slave io
);
   localparam int N  = WIDTH / STEP;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   state_t           nxt;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_nxt;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             c_out;
   logic             c_msb;
   logic             last;
   logic [STEP-1:0]  s;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             done_q;

   // operands shift right each cycle so the active slice is always the low STEP bits
   always_comb begin
      logic c;
      c     = carry;
      c_msb = 1'b0;
      s     = '0;
      for (int j = 0; j < STEP; j++) begin
         if (j == STEP - 1) c_msb = c;
         s[j] = opa[j] ^ opb[j] ^ c;
         c    = (opa[j] & opb[j]) | (c & (opa[j] ^ opb[j]));
      end
      c_out = c;
   end

   assign res_nxt = (res >> STEP) | (WIDTH'(s) << (WIDTH - STEP));
   assign last    = (cnt == CW'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE: if (io.start) nxt = RUN;
         RUN:  if (last)     nxt = IDLE;
         default:            nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa    <= '0;
         opb    <= '0;
         res    <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (io.start) begin
                  opa   <= io.a;
                  opb   <= io.b ^ {WIDTH{io.sub}};
                  carry <= io.sub;
                  cnt   <= '0;
                  res   <= '0;
               end
            end
            RUN: begin
               opa   <= opa >> STEP;
               opb   <= opb >> STEP;
               res   <= res_nxt;
               carry <= c_out;
               cnt   <= cnt + CW'(1);
               if (last) begin
                  sum_q  <= res_nxt;
                  cout_q <= c_out;
                  ovf_q  <= c_msb ^ c_out;
                  done_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign io.busy = (state == RUN);
   assign io.done = done_q;
   assign io.sum  = sum_q;
   assign io.cout = cout_q;
   assign io.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: 8/1 vector table plus
// abort, ignored-start and parameter-sweep sequences.
module tb_serial_addsub;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   serial_addsub_if #(.WIDTH(8))  i0 ();
   serial_addsub_if #(.WIDTH(8))  i4 ();
   serial_addsub_if #(.WIDTH(8))  i8 ();
   serial_addsub_if #(.WIDTH(16)) i16 ();

   serial_addsub #(.WIDTH(8), .STEP(1)) u0 (
      .clk(clk), .rst_n(rst_n), .io(i0.slave));
   serial_addsub #(.WIDTH(8), .STEP(4)) u4 (
      .clk(clk), .rst_n(rst_n), .io(i4.slave));
   serial_addsub #(.WIDTH(8), .STEP(8)) u8 (
      .clk(clk), .rst_n(rst_n), .io(i8.slave));
   serial_addsub #(.WIDTH(16), .STEP(2)) u16 (
      .clk(clk), .rst_n(rst_n), .io(i16.slave));

   typedef struct {
      logic       sub;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   vec_t vecs [9];
   int   pass_cnt = 0;
   int   total_cnt = 0;
   logic [7:0] exp_prev = 8'h00;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         pass_cnt++;
   endtask

   task automatic run_op(input int idx, input logic s, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] es,
                         input logic ec, input logic eo);
      int cyc;
      int busy_n;
      logic hold_ok;
      logic [7:0] got_sum;
      logic got_c;
      logic got_o;
      cyc = 0;
      busy_n = 0;
      hold_ok = 1'b1;
      got_sum = 8'hxx;
      got_c = 1'bx;
      got_o = 1'bx;
      @(negedge clk);
      i0.sub = s; i0.a = a; i0.b = b; i0.start = 1'b1;
      while (cyc < 40) begin
         @(negedge clk);
         i0.start = 1'b0;
         cyc++;
         if (i0.done) begin
            got_sum = i0.sum; got_c = i0.cout; got_o = i0.ovf;
            break;
         end
         if (i0.busy) busy_n++;
         if (i0.sum !== exp_prev) hold_ok = 1'b0;
      end
      chk($sformatf("v%0d_lat", idx), cyc - 1, 8);
      chk($sformatf("v%0d_busy", idx), busy_n, 8);
      chk($sformatf("v%0d_hold", idx), {31'd0, hold_ok}, 1);
      chk($sformatf("v%0d_sum", idx), {24'd0, got_sum}, {24'd0, es});
      chk($sformatf("v%0d_cout", idx), {31'd0, got_c}, {31'd0, ec});
      chk($sformatf("v%0d_ovf", idx), {31'd0, got_o}, {31'd0, eo});
      @(negedge clk);
      chk($sformatf("v%0d_pulse", idx), {31'd0, i0.done}, 0);
      exp_prev = es;
   endtask

   initial begin
      int cyc;
      int seen;
      int lat;
      logic [7:0] dpat;
      logic [7:0] sum_at;

      vecs[0] = '{1'b0, 8'h10, 8'h01, 8'h11, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
      vecs[5] = '{1'b0, 8'h0A, 8'h05, 8'h0F, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
      vecs[7] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
      vecs[8] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};

      {i0.start, i0.sub, i0.a, i0.b} = '0;
      {i4.start, i4.sub, i4.a, i4.b} = '0;
      {i8.start, i8.sub, i8.a, i8.b} = '0;
      {i16.start, i16.sub, i16.a, i16.b} = '0;

      repeat (3) @(negedge clk);
      chk("reset_out", {20'd0, i0.busy, i0.done, i0.cout, i0.ovf, i0.sum}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_out", {20'd0, i0.busy, i0.done, i0.cout, i0.ovf, i0.sum}, 0);

      for (int i = 0; i < 9; i++)
         run_op(i, vecs[i].sub, vecs[i].a, vecs[i].b,
                vecs[i].sum, vecs[i].cout, vecs[i].ovf);

      // start while busy must be ignored
      @(negedge clk);
      i0.sub = 1'b0; i0.a = 8'h01; i0.b = 8'h01; i0.start = 1'b1;
      cyc = 0; seen = 0; lat = 0; sum_at = 8'h00;
      while (cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) i0.start = 1'b0;
         if (cyc == 3) begin
            i0.start = 1'b1; i0.a = 8'hF0; i0.b = 8'h0F; i0.sub = 1'b1;
         end
         if (cyc == 4) i0.start = 1'b0;
         if (i0.done) begin
            seen++;
            if (seen == 1) begin lat = cyc - 1; sum_at = i0.sum; end
         end
      end
      chk("ign_lat", lat, 8);
      chk("ign_sum", {24'd0, sum_at}, 32'h02);
      chk("ign_dones", seen, 1);
      chk("ign_held", {24'd0, i0.sum}, 32'h02);

      // asynchronous abort mid-operation
      @(negedge clk);
      i0.sub = 1'b0; i0.a = 8'h33; i0.b = 8'h44; i0.start = 1'b1;
      @(negedge clk);
      i0.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_abort_busy", {31'd0, i0.busy}, 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_out", {20'd0, i0.busy, i0.done, i0.cout, i0.ovf, i0.sum}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_prev = 8'h00;
      run_op(20, 1'b0, 8'h0A, 8'h05, 8'h0F, 1'b0, 1'b0);

      // STEP=4: two-cycle latency
      @(negedge clk);
      i4.sub = 1'b0; i4.a = 8'h7F; i4.b = 8'h01; i4.start = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         i4.start = 1'b0;
         cyc++;
      end while (!i4.done && cyc < 20);
      chk("s4_lat", cyc - 1, 2);
      chk("s4_res", {21'd0, i4.cout, i4.ovf, i4.sum}, {21'd0, 1'b0, 1'b1, 8'h80});

      // STEP=8: start held high gives done every other cycle
      @(negedge clk);
      i8.sub = 1'b0; i8.a = 8'h01; i8.b = 8'h02; i8.start = 1'b1;
      dpat = 8'h00;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         dpat[k] = i8.done;
      end
      i8.start = 1'b0;
      chk("s8_pattern", {24'd0, dpat}, 32'hAA);
      chk("s8_res", {22'd0, i8.cout, i8.ovf, i8.sum}, 32'h03);

      // WIDTH=16, STEP=2
      @(negedge clk);
      i16.sub = 1'b0; i16.a = 16'h8000; i16.b = 16'h8000; i16.start = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         i16.start = 1'b0;
         cyc++;
      end while (!i16.done && cyc < 30);
      chk("s16_lat", cyc - 1, 8);
      chk("s16_res", {14'd0, i16.cout, i16.ovf, i16.sum}, {14'd0, 1'b1, 1'b1, 16'h0000});
      @(negedge clk);
      i16.sub = 1'b1; i16.a = 16'h0000; i16.b = 16'h0001; i16.start = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         i16.start = 1'b0;
         cyc++;
      end while (!i16.done && cyc < 30);
      chk("s16_sub", {14'd0, i16.cout, i16.ovf, i16.sum}, {14'd0, 1'b0, 1'b0, 16'hFFFF});

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Multi-cycle, parametrised adder/subtractor that replaces fixed-width ripple chains where area matters more than latency.
- Each clock it processes STEP bits of a WIDTH-bit operation through a STEP-bit ripple slice of full adders, carrying between cycles in a register.
- Start/done handshake toward a controller; results, carry-out and signed overflow stay held until the next start.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).
- STEP, 1, bits processed per cycle; must divide WIDTH exactly; STEP = WIDTH gives single-cycle operation.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request a new operation; sampled only when busy = 0.
- sub  in  1  0 = a+b, 1 = a-b; captured with start.
- a  in  WIDTH  operand A; captured with start.
- b  in  WIDTH  operand B; captured with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when the result becomes valid.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB; for sub, 1 = no borrow.
- ovf  out  1  two's-complement overflow of the operation.

Behaviour:
- Reset (rst_n = 0, at any time, including mid-operation):
  - State goes to IDLE immediately, aborting any operation in progress.
  - busy = 0, done = 0, sum = 0, cout = 0, ovf = 0.
  - Internal operand, carry and counter registers are cleared.
- States:
  - IDLE -> RUN on a clock edge with start = 1.
  - RUN -> IDLE after N = WIDTH/STEP RUN cycles.
- Start capture at edge k:
  - Latch a, and b XOR {WIDTH{sub}.
  - Carry register <= sub.
  - Slice counter <= 0, busy <= 1.
  - done <= 0. sum, cout and ovf keep their previous values until completion.
- RUN: each edge adds slice i (bits STEP*i+STEP-1 .. STEP*i) of the latched operands plus the carry register.
  - Write the STEP result bits into the internal result register.
  - Update the carry register; increment i.
- Completion: on the edge that processes slice N-1, i.e. edge k+N:
  - sum <= full result.
  - cout <= final carry.
  - ovf <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - done <= 1, busy <= 0.
- done is high for exactly one cycle, the cycle after edge k+N. Latency from start to done is N cycles.
- start while busy = 1 is ignored; captured operands are unaffected.
- start asserted in the same cycle as done is accepted: back-to-back operation, and done deasserts on the next edge.
- start held high continuously issues a new operation every N+1 cycles.
- Inputs a, b, sub may change freely while busy = 1.
- Outputs change only at completion or reset; no other edge alters sum, cout or ovf.

Test Plan (WIDTH = 8, STEP = 1 unless stated):
- Reset, then a=0x10, b=0x01, sub=0, one-cycle start -> busy high 8 cycles; done pulses one cycle; sum=0x11, cout=0, ovf=0.
- a=0xFF, b=0x01, add -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- sub, a=0x05, b=0x07 -> sum=0xFE, cout=0 (borrow), ovf=0. Then sub, a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- Start a=0x01, b=0x01; at cycle 3 pulse start with a=0xF0 -> ignored; result sum=0x02, and no second done follows.
- Start a=0x33, b=0x44; drop rst_n at cycle 4 -> immediately busy=0, done=0, sum=0; after release, a new start with a=0x0A, b=0x05 completes with sum=0x0F.
- Parameter sweeps:
  - STEP=4: latency 2.
  - STEP=8: latency 1; back-to-back starts give done every 2 cycles.
  - WIDTH=16, STEP=2: 0x8000+0x8000 -> sum=0x0000, cout=1, ovf=1.
